// File: rtl/io_bus_pkg.sv
// io_bus_pkg: shared definitions for the I/O bus controller.
//   - Default parameter constants used by io_bus_ctrl.
//   - FSM state encoding. It is shared so the debug state output can be
//     decoded by anything that imports this package.
package io_bus_pkg;

   localparam int DEF_DATA_W     = 8;
   localparam int DEF_PORT_AW    = 4;
   localparam int DEF_FIFO_DEPTH = 4;
   localparam int DEF_STROBE_CYC = 1;
   localparam int DEF_TURN_CYC   = 1;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WR_SETUP  = 3'd1,
      S_WR_STROBE = 3'd2,
      S_WR_HOLD   = 3'd3,
      S_RD_TURN   = 3'd4,
      S_RD_SAMPLE = 3'd5
   } bus_state_t;

endpackage

// File: rtl/io_wr_fifo.sv
// io_wr_fifo: posted-write FIFO for the I/O bus controller.
// Ports:
//   clk, reset  - clock and synchronous active-high reset (empties the FIFO)
//   push, din   - write an entry; ignored while full
//   pop         - drop the head entry; ignored while empty
//   head        - current head entry (combinational read)
//   full, empty - derived from the registered count only
//   level       - number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module io_wr_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];
   assign level   = count;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         // Simultaneous push and pop leave the count unchanged.
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only read while count says valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl: CPU-side I/O request port to a shared bidirectional I/O bus.
// Writes are posted into a FIFO and replayed onto the bus as
// SETUP / STROBE (STROBE_CYC cycles) / HOLD. Reads wait until every posted
// write has left the bus, then spend TURN_CYC idle cycles before sampling.
//
// Handshake: cpu_req is valid and the CPU holds cpu_req/cpu_we/cpu_port/
// cpu_wdata stable until cpu_ready. A write completes in the cycle where
// cpu_ready=1 (ready = FIFO not full, combinational); a read completes in the
// cycle cpu_ready=1, with cpu_rdata valid in that same cycle.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   cpu_req, cpu_we       - request valid, 1=write 0=read
//   cpu_port, cpu_wdata   - target port, write data
//   cpu_ready, cpu_rdata  - accept/done strobe, read data (held until next read)
//   io_data               - bidirectional bus, driven only while io_oe=1
//   io_addr, io_oe, io_we - bus address, output enable, write strobe
//   fifo_level            - posted writes outstanding
//   busy                  - FSM active or writes pending
//   dbg_state             - current FSM state (bus_state_t encoding)
module io_bus_ctrl
   import io_bus_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int PORT_AW    = DEF_PORT_AW,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int STROBE_CYC = DEF_STROBE_CYC,
   parameter int TURN_CYC   = DEF_TURN_CYC
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          cpu_req,
   input  logic                          cpu_we,
   input  logic [PORT_AW-1:0]            cpu_port,
   input  logic [DATA_W-1:0]             cpu_wdata,
   output logic                          cpu_ready,
   output logic [DATA_W-1:0]             cpu_rdata,
   inout  wire  [DATA_W-1:0]             io_data,
   output logic [PORT_AW-1:0]            io_addr,
   output logic                          io_oe,
   output logic                          io_we,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          busy,
   output logic [2:0]                    dbg_state
);

   localparam int ENTRY_W = PORT_AW + DATA_W;
   localparam int CNT_MAX = (STROBE_CYC > TURN_CYC) ? STROBE_CYC : TURN_CYC;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] TURN_LAST   = CNT_W'(TURN_CYC - 1);

   bus_state_t           state_q;
   bus_state_t           state_d;
   logic [CNT_W-1:0]     cnt_q;
   logic                 fifo_push;
   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [ENTRY_W-1:0]   fifo_head;
   logic [PORT_AW-1:0]   head_addr;
   logic [DATA_W-1:0]    head_data;
   logic [DATA_W-1:0]    rdata_q;
   logic                 rd_done;

   io_wr_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .din   ({cpu_port, cpu_wdata}),
      .pop   (fifo_pop),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign {head_addr, head_data} = fifo_head;

   // Full comes from the registered count, so a pop in the same cycle
   // never frees a slot for a push.
   assign fifo_push = cpu_req && cpu_we && !fifo_full;
   assign cpu_ready = fifo_push || rd_done;

   assign io_data   = io_oe ? head_data : {DATA_W{1'bz}};

   // During the sample cycle the bus value is forwarded so cpu_rdata is
   // valid alongside cpu_ready; afterwards the captured copy is held.
   assign cpu_rdata = rd_done ? io_data : rdata_q;

   assign busy      = (state_q != S_IDLE) || !fifo_empty;
   assign dbg_state = state_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         // Counter measures time spent in the current state.
         if (state_d != state_q) cnt_q <= '0;
         else                    cnt_q <= cnt_q + CNT_W'(1);
         if (rd_done) rdata_q <= io_data;
      end
   end

   always_comb begin
      state_d  = state_q;
      io_oe    = 1'b0;
      io_we    = 1'b0;
      io_addr  = '0;
      fifo_pop = 1'b0;
      rd_done  = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Pending writes win; a read only goes out on an empty FIFO.
            if (!fifo_empty)           state_d = S_WR_SETUP;
            else if (cpu_req && !cpu_we) state_d = S_RD_TURN;
         end
         S_WR_SETUP: begin
            io_oe   = 1'b1;
            io_addr = head_addr;
            state_d = S_WR_STROBE;
         end
         S_WR_STROBE: begin
            io_oe   = 1'b1;
            io_we   = 1'b1;
            io_addr = head_addr;
            if (cnt_q == STROBE_LAST) state_d = S_WR_HOLD;
         end
         S_WR_HOLD: begin
            io_oe    = 1'b1;
            io_addr  = head_addr;
            fifo_pop = 1'b1;
            state_d  = S_IDLE;
         end
         S_RD_TURN: begin
            io_addr = cpu_port;
            if (cnt_q == TURN_LAST) state_d = S_RD_SAMPLE;
         end
         S_RD_SAMPLE: begin
            io_addr = cpu_port;
            rd_done = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule
